// File: rtl/weight_loader.sv
// weight_loader: write-side sequencer for the layer-1 weight SRAM.
// Accepts a serial stream of weight bytes over valid/ready and turns it into
// pixel/neuron-addressed writes. The neuron address is the inner loop and the
// pixel address is the outer loop. The memory is filled in one pass, and busy
// keeps the read sequencer away while loading.
// Optional feature: define WL_CHECKSUM_EN to build a 24-bit running byte sum
// on the checksum port. Without the macro the port is tied to zero.
module weight_loader #(
    parameter int BIT_NUMBER    = 8,
    parameter int PIXEL_NUMBER  = 784,
    parameter int NEURAL_NUMBER = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIT_NUMBER-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIT_NUMBER-1:0] mem_datain,
    output logic [9:0]            mem_pixel_addr,
    output logic [4:0]            mem_neural_addr,
    output logic                  mem_wt,
    output logic                  busy,
    output logic                  done,
    output logic [23:0]           checksum
);

    // Last legal counter values. Counters stop here and never run past them.
    localparam logic [9:0] PIX_LAST = 10'(PIXEL_NUMBER - 1);
    localparam logic [4:0] NEU_LAST = 5'(NEURAL_NUMBER - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [9:0]            r_pix_cnt;
    logic [4:0]            r_neu_cnt;
    logic                  r_in_ready;
    logic [BIT_NUMBER-1:0] r_mem_datain;
    logic [9:0]            r_mem_pixel_addr;
    logic [4:0]            r_mem_neural_addr;
    logic                  r_mem_wt;
    logic                  r_busy;
    logic                  r_done;

    logic w_beat;
    logic w_last_beat;
    logic w_start_accept;

    // A beat is a byte accepted on this edge. in_ready is only high in LOAD.
    assign w_beat         = (r_state == S_LOAD) && r_in_ready && in_valid;
    assign w_last_beat    = (r_pix_cnt == PIX_LAST) && (r_neu_cnt == NEU_LAST);
    assign w_start_accept = (r_state == S_IDLE) && start;

    // Sequencer FSM: state, address counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_pix_cnt         <= '0;
            r_neu_cnt         <= '0;
            r_in_ready        <= 1'b0;
            r_mem_datain      <= '0;
            r_mem_pixel_addr  <= '0;
            r_mem_neural_addr <= '0;
            r_mem_wt          <= 1'b0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            // NOTE: every register here is assigned with <=, so the counters and
            // outputs all see their pre-edge values within this block. The two
            // pulse outputs get a default first; everything else holds its value
            // by not being assigned.
            r_mem_wt <= 1'b0;
            r_done   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_start_accept) begin
                        r_state    <= S_LOAD;
                        r_pix_cnt  <= '0;
                        r_neu_cnt  <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (w_beat) begin
                        // The write is presented in the cycle after acceptance.
                        r_mem_datain      <= in_data;
                        r_mem_pixel_addr  <= r_pix_cnt;
                        r_mem_neural_addr <= r_neu_cnt;
                        r_mem_wt          <= 1'b1;
                        if (w_last_beat) begin
                            // Counters stay at their last values. The final
                            // strobe is presented during FLUSH.
                            r_state    <= S_FLUSH;
                            r_in_ready <= 1'b0;
                        end else if (r_neu_cnt == NEU_LAST) begin
                            r_neu_cnt <= '0;
                            r_pix_cnt <= r_pix_cnt + 10'd1;
                        end else begin
                            r_neu_cnt <= r_neu_cnt + 5'd1;
                        end
                    end
                end

                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end

                S_DONE: begin
                    // A start seen here is dropped; only IDLE samples start.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef WL_CHECKSUM_EN
    logic [23:0] r_checksum;

    // Running byte sum. It restarts on each accepted start and holds after done.
    // 15680 * 255 fits in 24 bits, so no saturation is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_accept) begin
            r_checksum <= '0;
        end else if (w_beat) begin
            r_checksum <= r_checksum + 24'(in_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 24'd0;
`endif

    assign in_ready        = r_in_ready;
    assign mem_datain      = r_mem_datain;
    assign mem_pixel_addr  = r_mem_pixel_addr;
    assign mem_neural_addr = r_mem_neural_addr;
    assign mem_wt          = r_mem_wt;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Write-side sequencer for the layer-1 weight SRAM (784 pixels x 20 neurons, 8-bit).
- Accepts a serial byte stream of trained weights over a valid/ready handshake.
- Generates the pixel/neuron write addresses, data and write strobe, so the memory is filled in one pass without host address bookkeeping.
- Sits between the off-chip/testbench weight source and the weight memory; asserts busy so the read sequencer keeps rd low during loading.

Parameters:
- BIT_NUMBER, 8, weight width in bits.
- PIXEL_NUMBER, 784, number of pixel rows (outer loop).
- NEURAL_NUMBER, 20, number of neurons per pixel row (inner loop).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a full load; sampled only in IDLE.
- in_data  input  BIT_NUMBER  weight byte from the source.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_datain  output  BIT_NUMBER  write data to the weight memory.
- mem_pixel_addr  output  10  pixel write address.
- mem_neural_addr  output  5  neuron write address.
- mem_wt  output  1  write strobe to the weight memory.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse after the final write.
- checksum  output  24  running byte sum (see Optional Feature).

Behaviour:
- Reset:
  - Asynchronous on rst_n=0.
  - State goes to IDLE; counters are cleared.
  - All outputs are 0: in_ready, mem_datain, mem_pixel_addr, mem_neural_addr, mem_wt, busy, done, checksum.
- State machine:
  - IDLE: in_ready=0. On start=1, go to LOAD and clear pix_cnt, neu_cnt (and checksum).
  - LOAD: in_ready=1 (registered, high from the first LOAD cycle). A beat is in_valid & in_ready at a rising edge.
    - On each beat, register mem_datain<=in_data, mem_pixel_addr<=pix_cnt, mem_neural_addr<=neu_cnt, mem_wt<=1.
    - Write latency is one cycle: the strobe is presented in the cycle after acceptance and the memory commits on the following edge.
    - Without a beat, mem_wt<=0 and the address/data outputs hold their values.
  - Counter order: neu_cnt is the inner loop 0..NEURAL_NUMBER-1; it wraps to 0 and increments pix_cnt. Byte k is written to pixel k/20, neuron k%20.
  - Last beat is the one with pix_cnt=783 and neu_cnt=19. It goes to FLUSH; in_ready drops in the next cycle. Total beats are exactly 15680.
  - FLUSH (1 cycle): the final mem_wt=1 is presented; in_ready=0. Go to DONE.
  - DONE (1 cycle): done=1, mem_wt=0. Go to IDLE.
- busy is 1 in LOAD, FLUSH and DONE. mem_wt is never high for two cycles unless two consecutive beats were accepted.
- Stalls: in_valid low for any number of cycles is legal. Counters and outputs hold; there is no timeout.
- start is ignored in LOAD, FLUSH and DONE. A start coincident with the DONE->IDLE transition is ignored.
- Reset mid-load aborts immediately: mem_wt drops asynchronously. Memory contents already written are not cleared; a new start reloads from address 0.
- Counter widths: pix_cnt 10 bits, neu_cnt 5 bits. Comparisons are against PIXEL_NUMBER-1 and NEURAL_NUMBER-1. Counters never exceed these values.

Optional Feature:
- Macro: WL_CHECKSUM_EN.
- Defined:
  - checksum is a 24-bit unsigned sum of all accepted in_data bytes, zero-extended.
  - Cleared on the start acceptance cycle; updated at each beat edge; held after done until the next start.
  - Maximum value is 15680*255 = 3,998,400, so it cannot overflow.
- Undefined: the checksum port still exists and is tied to 0; no adder is built.

Test Plan:
- Reset, then start, then 15680 bytes of value k%256 with in_valid always high:
  - one mem_wt pulse per byte; byte 0 -> (0,0), byte 19 -> (0,19), byte 20 -> (1,0), byte 15679 -> (783,19);
  - done is 1 exactly 2 cycles after the last accepted beat; busy falls with done's cycle end.
- Random in_valid gaps (about 50% duty): address sequence identical to the first test; mem_wt is low in every cycle following a non-beat; no byte is lost or duplicated.
- start pulsed again mid-LOAD at byte 500: ignored; pixel/neuron sequence continues from (25,0); done occurs once.
- rst_n low at byte 1000: all outputs 0 asynchronously. Then start plus a full stream: the first write is at (0,0).
- With WL_CHECKSUM_EN, stream all 0xFF: checksum = 3,998,400 at done. Without the macro: checksum = 0 throughout.
- Reference-model check: memory model written from mem_* outputs, then read back with rd=1. Every pixel row matches the streamed bytes, and rd was never asserted while busy=1.
